block_move_ctrl: RTL and testbench
==================================

// Module: block_move_ctrl
// PURPOSE
//  Parametrised successor to the two-key block mover. Takes four debounced key pulses
//  (up/down/left/right) and holds a block position on a configurable screen. Moves are
//  committed only at frame start, so the block never tears mid-frame. Clamp or wrap
//  edge mode is selectable. Returns registered pixel colour for the vga_ctrl query (xide, yide).
// PARAMETERS
//  H_ACTIVE    640      visible pixels per line
//  V_ACTIVE    480      visible lines per frame
//  BLK_W       32       block width, pixels (1..H_ACTIVE)
//  BLK_H       32       block height, lines (1..V_ACTIVE)
//  STEP        8        pixels moved per committed key press (1..BLK_W)
//  X_INIT      304      reset x of block top-left corner
//  Y_INIT      224      reset y of block top-left corner
//  WRAP        0        0 = clamp at screen edge, 1 = wrap to the opposite edge
//  FG_COLOUR   8'hFF    vga_data value inside the block
//  BG_COLOUR   8'h00    vga_data value outside the block
// PORTS
//  clk          in   1   pixel clock; every input is synchronous to it
//  rst          in   1   asynchronous, active-high reset
//  key_up       in   1   1-cycle pulse: move up by STEP
//  key_down     in   1   1-cycle pulse: move down by STEP
//  key_left     in   1   1-cycle pulse: move left by STEP
//  key_right    in   1   1-cycle pulse: move right by STEP
//  frame_start  in   1   1-cycle pulse at the start of vertical blanking
//  vga_xide     in   10  x of the queried pixel
//  vga_yide     in   10  y of the queried pixel
//  vga_data     out  8   colour for the queried pixel
//  pos_x        out  10  current block x (top-left corner)
//  pos_y        out  10  current block y (top-left corner)
//  move_cnt     out  16  count of commits that changed position; wraps at 16'hFFFF
// BEHAVIOUR
//  Reset values:
//   - pos_x = X_INIT, pos_y = Y_INIT, vga_data = BG_COLOUR, move_cnt = 0.
//   - All pending flags cleared; FSM in IDLE.
//  Pending flags:
//   - One sticky flag per direction. A key pulse sets its flag.
//   - Repeated pulses within one frame give one step, not several.
//  FSM states and transitions:
//   - IDLE: no flag set. Any pulse -> ARMED.
//   - ARMED: waits. frame_start -> COMMIT.
//   - COMMIT (1 cycle): applies all set flags, clears them, then -> IDLE.
//   - A pulse that arrives in COMMIT stays set and forces ARMED instead of IDLE.
//   - frame_start in IDLE does nothing.
//  Net motion in COMMIT:
//   - dx = STEP*(right-left), dy = STEP*(down-up).
//   - Opposite flags cancel on their axis. Diagonal moves are allowed.
//  Arithmetic:
//   - 12-bit signed intermediate; limits XMAX = H_ACTIVE-BLK_W, YMAX = V_ACTIVE-BLK_H.
//   - Clamp (WRAP=0): result saturates to [0, XMAX] / [0, YMAX].
//   - Wrap (WRAP=1): n<0 gives n+XMAX+1; n>XMAX gives n-(XMAX+1). Y uses YMAX the same way.
//  move_cnt increments in COMMIT only when pos_x or pos_y actually changes.
//   - A clamped no-op does not count.
//  Pixel path:
//   - in_blk = (xide >= pos_x) && (xide < pos_x+BLK_W) && (yide >= pos_y) && (yide < pos_y+BLK_H).
//   - Compares use 11-bit width, so there is no overflow.
//   - vga_data = in_blk ? FG_COLOUR : BG_COLOUR, registered, 1 clk latency.
//   - pos_x/pos_y change only in COMMIT, so pixels inside one frame are consistent.
//  Reset during ARMED discards all pending moves.
//  A key pulse in the same cycle as rst is ignored.
// STRUCTURE
//  Shared package (vga_pkg):
//   - FSM state enum {IDLE, ARMED, COMMIT}.
//   - Screen timing constants H_ACTIVE/V_ACTIVE shared with vga_ctrl.
//  One sub-module: block_axis_step.
//   - Inputs: pos, inc, dec. Parameters: STEP, MAX, WRAP. Output: next pos.
//   - Instantiated twice, once for x and once for y.
// TESTING
//  1. Reset, then read pixel (304,224) and pixel (0,0):
//     vga_data is FG then BG, each 1 clk after the query.
//  2. Three key_right pulses, then one frame_start:
//     pos_x 304->312 after a single step; move_cnt=1.
//  3. key_left and key_right in the same frame, then frame_start:
//     pos_x unchanged; move_cnt unchanged.
//  4. WRAP=0, pos_x=604, key_right, commit:
//     pos_x=608 (XMAX). Repeat: pos_x stays 608 and move_cnt does not increment.
//  5. WRAP=1, pos_y=4, key_up, commit:
//     pos_y = 4-8+449 = 445.
//  6. key_down pulse, then rst asserted before frame_start:
//     pos_y=Y_INIT and the pending move is lost.
//     A key pulse in the COMMIT cycle is applied at the next frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible screen size and the block mover FSM states.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } move_state_t;

    // Key bit positions inside the pending-flag vector.
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_UP    = 3;

    // True when at least one direction flag is set.
    function automatic logic any_key(input logic [3:0] keys);
        return |keys;
    endfunction

endpackage

// File: rtl/block_axis_step.sv
// One axis of block motion: applies +/-STEP and limits the result to [0, MAX]
// by saturating (WRAP=0) or by wrapping to the opposite edge (WRAP=1).
module block_axis_step #(
    parameter int STEP = 8,
    parameter int MAX  = 608,
    parameter bit WRAP = 1'b0
) (
    input  logic [9:0] pos,
    input  logic       inc,
    input  logic       dec,
    output logic [9:0] next
);

    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] MAX_S  = 12'(MAX);

    logic signed [11:0] delta_s;
    logic signed [11:0] sum_s;

    // Net step on this axis; opposite requests cancel, then limit to the screen.
    always_comb begin
        delta_s = 12'sd0;
        if (inc && !dec) begin
            delta_s = STEP_S;
        end else if (dec && !inc) begin
            delta_s = -STEP_S;
        end else begin
            delta_s = 12'sd0;
        end

        sum_s = $signed({2'b00, pos}) + delta_s;

        if (sum_s < 12'sd0) begin
            if (WRAP) begin
                next = 10'(sum_s + MAX_S + 12'sd1);
            end else begin
                next = 10'd0;
            end
        end else if (sum_s > MAX_S) begin
            if (WRAP) begin
                next = 10'(sum_s - MAX_S - 12'sd1);
            end else begin
                next = MAX_S[9:0];
            end
        end else begin
            next = sum_s[9:0];
        end
    end

endmodule

// File: rtl/block_move_ctrl.sv
// Block mover: latches key presses as sticky flags, commits them once at frame
// start so the block never tears mid-frame, and renders the block for vga_ctrl.
module block_move_ctrl
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int         V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int         BLK_W     = 32,
    parameter int         BLK_H     = 32,
    parameter int         STEP      = 8,
    parameter int         X_INIT    = 304,
    parameter int         Y_INIT    = 224,
    parameter bit         WRAP      = 1'b0,
    parameter logic [7:0] FG_COLOUR = 8'hFF,
    parameter logic [7:0] BG_COLOUR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        frame_start,
    input  logic [9:0]  vga_xide,
    input  logic [9:0]  vga_yide,
    output logic [7:0]  vga_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [15:0] move_cnt
);

    localparam int XMAX = H_ACTIVE - BLK_W;
    localparam int YMAX = V_ACTIVE - BLK_H;

    move_state_t state_r;
    logic [3:0]  pend_r;
    logic [3:0]  keys_s;
    logic [9:0]  next_x_s;
    logic [9:0]  next_y_s;
    logic        in_blk_s;

    assign keys_s = {key_up, key_down, key_left, key_right};

    block_axis_step #(.STEP(STEP), .MAX(XMAX), .WRAP(WRAP)) u_step_x (
        .pos  (pos_x),
        .inc  (pend_r[KEY_RIGHT]),
        .dec  (pend_r[KEY_LEFT]),
        .next (next_x_s)
    );

    block_axis_step #(.STEP(STEP), .MAX(YMAX), .WRAP(WRAP)) u_step_y (
        .pos  (pos_y),
        .inc  (pend_r[KEY_DOWN]),
        .dec  (pend_r[KEY_UP]),
        .next (next_y_s)
    );

    // Move FSM: collect flags, wait for frame start, apply all flags in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            pend_r   <= 4'b0000;
            pos_x    <= 10'(X_INIT);
            pos_y    <= 10'(Y_INIT);
            move_cnt <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    pend_r <= pend_r | keys_s;
                    if (any_key(keys_s)) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    pend_r <= pend_r | keys_s;
                    if (frame_start) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= ARMED;
                    end
                end
                COMMIT: begin
                    pos_x <= next_x_s;
                    pos_y <= next_y_s;
                    if ((next_x_s != pos_x) || (next_y_s != pos_y)) begin
                        move_cnt <= move_cnt + 16'd1;
                    end else begin
                        move_cnt <= move_cnt;
                    end
                    // Presses landing in the commit cycle belong to the next frame.
                    pend_r <= keys_s;
                    if (any_key(keys_s)) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    pend_r  <= 4'b0000;
                end
            endcase
        end
    end

    // Hit test at 11 bits so pos+size never overflows.
    always_comb begin
        in_blk_s = ({1'b0, vga_xide} >= {1'b0, pos_x}) &&
                   ({1'b0, vga_xide} <  ({1'b0, pos_x} + 11'(BLK_W))) &&
                   ({1'b0, vga_yide} >= {1'b0, pos_y}) &&
                   ({1'b0, vga_yide} <  ({1'b0, pos_y} + 11'(BLK_H)));
    end

    // Registered pixel colour, one clock after the query.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_data <= BG_COLOUR;
        end else begin
            vga_data <= in_blk_s ? FG_COLOUR : BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_block_move_ctrl.sv
// Randomised and directed bench for block_move_ctrl: a clamp and a wrap
// instance share stimulus and are checked against a set-based reference model.
module tb_block_move_ctrl;

    localparam int XMAX = 640 - 32;
    localparam int YMAX = 480 - 32;

    logic        clk;
    logic        rst;
    logic        key_up, key_down, key_left, key_right, frame_start;
    logic [9:0]  vga_xide, vga_yide;
    logic [7:0]  data_c, data_w;
    logic [9:0]  px_c, py_c, px_w, py_w;
    logic [15:0] cnt_c, cnt_w;

    int n_pass;
    int n_total;

    // Reference model: pending direction set, a scheduled commit, and per-instance position.
    bit p_up, p_down, p_left, p_right;
    bit commit_due;
    int mx[2];
    int my[2];
    int mcnt[2];

    block_move_ctrl #(.WRAP(1'b0)) u_clamp (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .frame_start(frame_start), .vga_xide(vga_xide), .vga_yide(vga_yide),
        .vga_data(data_c), .pos_x(px_c), .pos_y(py_c), .move_cnt(cnt_c)
    );

    block_move_ctrl #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .frame_start(frame_start), .vga_xide(vga_xide), .vga_yide(vga_yide),
        .vga_data(data_w), .pos_x(px_w), .pos_y(py_w), .move_cnt(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int limit(input int n, input int max, input bit wrap);
        if (n < 0) return wrap ? n + max + 1 : 0;
        if (n > max) return wrap ? n - max - 1 : max;
        return n;
    endfunction

    function automatic int pixel(input int x, input int y, input int bx, input int by);
        return (x >= bx && x < bx + 32 && y >= by && y < by + 32) ? 32'hFF : 32'h00;
    endfunction

    task automatic model_reset();
        p_up = 0; p_down = 0; p_left = 0; p_right = 0;
        commit_due = 0;
        for (int i = 0; i < 2; i++) begin
            mx[i] = 304; my[i] = 224; mcnt[i] = 0;
        end
    endtask

    task automatic check_all(input string where, input int ec, input int ew);
        chk({where, "_pos_x_clamp"}, 32'(px_c), 32'(mx[0]));
        chk({where, "_pos_y_clamp"}, 32'(py_c), 32'(my[0]));
        chk({where, "_cnt_clamp"},   32'(cnt_c), 32'(mcnt[0]));
        chk({where, "_pix_clamp"},   32'(data_c), 32'(ec));
        chk({where, "_pos_x_wrap"},  32'(px_w), 32'(mx[1]));
        chk({where, "_pos_y_wrap"},  32'(py_w), 32'(my[1]));
        chk({where, "_cnt_wrap"},    32'(cnt_w), 32'(mcnt[1]));
        chk({where, "_pix_wrap"},    32'(data_w), 32'(ew));
    endtask

    // Called at a falling edge: drive one cycle, advance model, compare after the edge.
    task automatic cyc(input bit ku, input bit kd, input bit kl, input bit kr,
                       input bit fs, input int x, input int y);
        int ec, ew, nx, ny;
        key_up = ku; key_down = kd; key_left = kl; key_right = kr;
        frame_start = fs;
        vga_xide = 10'(x); vga_yide = 10'(y);
        @(posedge clk);
        ec = pixel(x, y, mx[0], my[0]);
        ew = pixel(x, y, mx[1], my[1]);
        if (commit_due) begin
            for (int i = 0; i < 2; i++) begin
                nx = limit(mx[i] + 8 * (int'(p_right) - int'(p_left)), XMAX, i == 1);
                ny = limit(my[i] + 8 * (int'(p_down) - int'(p_up)), YMAX, i == 1);
                if (nx != mx[i] || ny != my[i]) mcnt[i] = (mcnt[i] + 1) & 32'hFFFF;
                mx[i] = nx; my[i] = ny;
            end
            p_up = ku; p_down = kd; p_left = kl; p_right = kr;
            commit_due = 0;
        end else begin
            if ((p_up || p_down || p_left || p_right) && fs) commit_due = 1;
            p_up |= ku; p_down |= kd; p_left |= kl; p_right |= kr;
        end
        @(negedge clk);
        check_all("cyc", ec, ew);
    endtask

    // Reset with a key press in the same cycle; the press must be ignored.
    task automatic do_reset();
        rst = 1'b1;
        key_up = 1'b0; key_down = 1'b1; key_left = 1'b0; key_right = 1'b0;
        frame_start = 1'b0;
        model_reset();
        #1;
        check_all("rst_async", 32'h00, 32'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        key_down = 1'b0;
        check_all("rst_end", 32'h00, 32'h00);
    endtask

    task automatic press_commit(input bit ku, input bit kd, input bit kl, input bit kr);
        cyc(ku, kd, kl, kr, 1'b0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        int x, y;
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        frame_start = 1'b0; vga_xide = 10'd0; vga_yide = 10'd0;
        @(negedge clk);
        do_reset();

        // Pixel inside then outside the block.
        cyc(0, 0, 0, 0, 0, 304, 224);
        chk("pix_fg", 32'(data_c), 32'hFF);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("pix_bg", 32'(data_c), 32'h00);
        cyc(0, 0, 0, 0, 0, 335, 255);
        chk("pix_corner_in", 32'(data_c), 32'hFF);
        cyc(0, 0, 0, 0, 0, 336, 255);
        chk("pix_corner_out", 32'(data_c), 32'h00);

        // Three right presses in one frame give a single step.
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        press_commit(0, 0, 0, 1);
        chk("multi_press_x", 32'(px_c), 32'd312);
        chk("multi_press_cnt", 32'(cnt_c), 32'd1);

        // frame_start while idle does nothing.
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("idle_fs_x", 32'(px_c), 32'd312);

        // Opposite presses cancel and are not counted.
        cyc(0, 0, 1, 0, 0, 0, 0);
        press_commit(0, 0, 0, 1);
        chk("cancel_x", 32'(px_c), 32'd312);
        chk("cancel_cnt", 32'(cnt_c), 32'd1);

        // Walk right to the clamp limit, then push once more.
        for (int i = 0; i < 37; i++) press_commit(0, 0, 0, 1);
        chk("clamp_reach_x", 32'(px_c), 32'd608);
        chk("clamp_reach_cnt", 32'(cnt_c), 32'd38);
        press_commit(0, 0, 0, 1);
        chk("clamp_hold_x", 32'(px_c), 32'd608);
        chk("clamp_hold_cnt", 32'(cnt_c), 32'd38);
        chk("wrap_right_x", 32'(px_w), 32'd7);

        // Walk up to row 0 and past it: clamp holds, wrap jumps to 0-8+449.
        for (int i = 0; i < 29; i++) press_commit(1, 0, 0, 0);
        chk("clamp_top_y", 32'(py_c), 32'd0);
        chk("wrap_top_y", 32'(py_w), 32'd441);

        // Pending move discarded by reset.
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_discard_y", 32'(py_c), 32'd224);
        chk("rst_discard_cnt", 32'(cnt_c), 32'd0);

        // Press during the commit cycle waits for the next frame.
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("late_press_x", 32'(px_c), 32'd312);
        chk("late_press_y_held", 32'(py_c), 32'd224);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("late_press_y_moved", 32'(py_c), 32'd216);
        chk("late_press_cnt", 32'(cnt_c), 32'd2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    x = mx[$urandom_range(0, 1)] + int'($urandom_range(0, 35)) - 2;
                    y = my[$urandom_range(0, 1)] + int'($urandom_range(0, 35)) - 2;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                    if (x > 639) x = 639;
                    if (y > 479) y = 479;
                end else begin
                    x = int'($urandom_range(0, 639));
                    y = int'($urandom_range(0, 479));
                end
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 11) == 0, x, y);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
